// File: rtl/multicycle_controller.sv
// Multicycle CPU control unit: Moore FSM that sequences a 4-byte instruction
// fetch, decode and the per-opcode execute/writeback steps, driving datapath
// selects and enables from the current state.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic [3:0] irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucont,
  output logic [1:0] pcsource,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t cur;

  // Map an R-type funct field to an ALU operation; unknown codes fall back to add.
  function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
    case (f)
      6'b100000: funct_to_alu = ALU_ADD;
      6'b100010: funct_to_alu = ALU_SUB;
      6'b100100: funct_to_alu = ALU_AND;
      6'b100101: funct_to_alu = ALU_OR;
      6'b101010: funct_to_alu = ALU_SLT;
      default:   funct_to_alu = ALU_ADD;
    endcase
  endfunction

  // True when the funct field is one of the supported R-type operations.
  function automatic logic funct_known(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_known = 1'b1;
      default: funct_known = 1'b0;
    endcase
  endfunction

  // State register with next-state rules; reset (active-low) returns to FETCH1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur <= FETCH1;
    end else begin
      case (cur)
        FETCH1:  cur <= FETCH2;
        FETCH2:  cur <= FETCH3;
        FETCH3:  cur <= FETCH4;
        FETCH4:  cur <= DECODE;
        DECODE: begin
          case (op)
            OP_LB, OP_SB: cur <= MEMADR;
            OP_RTYPE:     cur <= RTYPEEX;
            OP_BEQ:       cur <= BEQEX;
            OP_J:         cur <= JEX;
            OP_ADDI:      cur <= ADDIEX;
            default:      cur <= FETCH1;
          endcase
        end
        MEMADR:  cur <= (op == OP_LB) ? LBRD : SBWR;
        LBRD:    cur <= LBWR;
        RTYPEEX: cur <= RTYPEWR;
        ADDIEX:  cur <= ADDIWR;
        default: cur <= FETCH1;
      endcase
    end
  end

  // Moore outputs decoded from the state; BEQ's pcen follows zero, and the
  // architectural enables are gated off while reset is held low.
  always_comb begin
    pcen     = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 4'b0000;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    alucont  = 3'b000;
    pcsource = 2'b00;
    case (cur)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        alusrcb = 2'b01;
        alucont = ALU_ADD;
        pcen    = 1'b1;
        irwrite = 4'b0001 << cur[1:0];
      end
      DECODE: begin
        alusrcb = 2'b11;
        alucont = ALU_ADD;
      end
      MEMADR, LBRD, SBWR: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        alucont  = ALU_ADD;
        iord     = (cur != MEMADR);
        memwrite = (cur == SBWR);
      end
      LBWR: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      RTYPEEX, RTYPEWR: begin
        alusrca  = 1'b1;
        alucont  = funct_to_alu(funct);
        regdst   = (cur == RTYPEWR);
        regwrite = (cur == RTYPEWR) && funct_known(funct);
      end
      ADDIEX, ADDIWR: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        alucont  = ALU_ADD;
        regwrite = (cur == ADDIWR);
      end
      BEQEX: begin
        alusrca  = 1'b1;
        alucont  = ALU_SUB;
        pcsource = 2'b01;
        pcen     = zero;
      end
      JEX: begin
        pcsource = 2'b10;
        pcen     = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      pcen     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 4'b0000;
      regwrite = 1'b0;
    end
  end

  assign state = cur;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters; width 8-bit datapath, 32-bit instruction fetched as 4 bytes.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low; sampled on rising clk edge.
REQ-004 op  input  6  instr[31:26] from datapath.
REQ-005 funct  input  6  instr[5:0] from datapath.
REQ-006 zero  input  1  ALU zero flag (combinational, current cycle).
REQ-007 pcen  output  1  PC register enable.
REQ-008 iord  output  1  0 = address from PC, 1 = address from ALU result.
REQ-009 memwrite  output  1  memory write strobe.
REQ-010 irwrite  output  4  one-hot instruction-byte load; bit0 loads instr[7:0].
REQ-011 regdst  output  1  0 = write rt (instr[20:16]), 1 = write rd (instr[15:11]).
REQ-012 memtoreg  output  1  0 = write ALU result, 1 = write memory data register.
REQ-013 regwrite  output  1  register file write enable.
REQ-014 alusrca  output  1  0 = PC, 1 = register A.
REQ-015 alusrcb  output  2  00 = B, 01 = constant 1, 10 = imm, 11 = imm<<2.
REQ-016 alucont  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-017 pcsource  output  2  00 = ALU result, 01 = ALU-out register, 10 = jump target.
REQ-018 state  output  4  current state encoding, for debug/verification.

Function
REQ-019 The FSM SHALL be Moore-encoded: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14; code 15 illegal, transitions to FETCH1.
REQ-020 Opcodes SHALL be LB=100000, SB=101000, RTYPE=000000, BEQ=000100, J=000010, ADDI=001000.
REQ-021 Transitions SHALL be: FETCH1->FETCH2->FETCH3->FETCH4->DECODE, unconditional, 1 cycle each.
REQ-022 DECODE SHALL branch: LB/SB->MEMADR, RTYPE->RTYPEEX, BEQ->BEQEX, J->JEX, ADDI->ADDIEX, any other op->FETCH1.
REQ-023 MEMADR->LBRD if op=LB, else SBWR; LBRD->LBWR; RTYPEEX->RTYPEWR; ADDIEX->ADDIWR.
REQ-024 LBWR, SBWR, RTYPEWR, ADDIWR, BEQEX, JEX SHALL transition to FETCH1.
REQ-025 Outputs not listed for a state SHALL be 0.
REQ-026 FETCHn: iord=0, alusrca=0, alusrcb=01, alucont=010, pcsource=00, pcen=1, irwrite bit n-1 set.
REQ-027 DECODE: alusrca=0, alusrcb=11, alucont=010 (branch target into ALU-out register).
REQ-028 MEMADR, LBRD, SBWR: alusrca=1, alusrcb=10, alucont=010; LBRD and SBWR add iord=1; SBWR adds memwrite=1.
REQ-029 LBWR: regdst=0, memtoreg=1, regwrite=1.
REQ-030 RTYPEEX and RTYPEWR: alusrca=1, alusrcb=00, alucont from funct; RTYPEWR adds regdst=1, regwrite=1.
REQ-031 Funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; other funct yields alucont=010 and regwrite=0 in RTYPEWR.
REQ-032 ADDIEX and ADDIWR: alusrca=1, alusrcb=10, alucont=010; ADDIWR adds regdst=0, regwrite=1.
REQ-033 BEQEX: alusrca=1, alusrcb=00, alucont=110, pcsource=01, pcen=zero (same-cycle, combinational).
REQ-034 JEX: pcsource=10, pcen=1.
REQ-035 Instruction latency SHALL be: LB 8, SB 7, RTYPE 7, ADDI 7, BEQ 6, J 6, unknown op 5 cycles.

Reset
REQ-036 On a rising edge with reset=0, state SHALL become FETCH1 regardless of current state, including mid-instruction.
REQ-037 While reset=0, pcen, memwrite, irwrite, regwrite SHALL be forced 0 combinationally; other outputs follow the state.
REQ-038 The first cycle after reset deasserts SHALL be FETCH1 with pcen=1, irwrite=0001.

Verification
REQ-039 Reset then op=000000, funct=100010 -> states 0,1,2,3,4,9,10,0; alucont=110 in states 9-10; regdst=1, regwrite=1 only in state 10.
REQ-040 op=000100, zero=1 in BEQEX -> pcen=1, pcsource=01; repeat with zero=0 -> pcen=0; next state 0 in both cases.
REQ-041 op=100000 -> states 0-4,5,6,7,0; iord=1 in state 6; memtoreg=1, regwrite=1 in state 7; memwrite never 1.
REQ-042 op=101000 -> state 8 with iord=1, memwrite=1, regwrite=0; op=111111 -> DECODE goes directly to FETCH1.
REQ-043 Assert reset=0 in state 7 (LBWR) -> regwrite=0 that cycle, state=0 next edge; RTYPE funct=000000 -> regwrite=0 in state 10.
